// File: rtl/ram_banked_ctrl.sv
// rtl/ram_banked_ctrl.sv - banked single-port synchronous RAM with valid/ready request/response
//
// Purpose: 2**BANK_SEL_BITS banks of BANK_DEPTH words, each word split into NUM_SLICES
// independently writable slices. Bank select is MSB (block) or LSB (interleaved) mapped.
// Optionally zeroes every word after reset before requests are accepted.
//
// Ports:
//   clk, rst                   rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready        request handshake (req_ready is combinational)
//   req_we/req_addr/req_wdata  write flag, word address, write data
//   req_be                     slice write enables (ignored for reads)
//   rsp_valid/rsp_ready        read response handshake
//   rsp_rdata                  read data, one cycle after read acceptance
//   init_done                  clear sequence finished
//   bank_active                one-hot bank of the last accepted request
module ram_banked_ctrl #(
  parameter int ADDR_WIDTH     = 14,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLICES     = 2,
  parameter int BANK_SEL_BITS  = 2,
  parameter int INTERLEAVE     = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_we,
  input  logic [ADDR_WIDTH-1:0]       req_addr,
  input  logic [DATA_WIDTH-1:0]       req_wdata,
  input  logic [NUM_SLICES-1:0]       req_be,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [DATA_WIDTH-1:0]       rsp_rdata,
  output logic                        init_done,
  output logic [2**BANK_SEL_BITS-1:0] bank_active
);

  localparam int NB         = 2**BANK_SEL_BITS;
  localparam int IDX_W      = ADDR_WIDTH - BANK_SEL_BITS;
  localparam int BANK_DEPTH = 2**IDX_W;
  localparam int SLICE_W    = DATA_WIDTH / NUM_SLICES;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]               state;
  logic [IDX_W-1:0]         init_cnt;
  logic [BANK_SEL_BITS-1:0] req_bank;
  logic [BANK_SEL_BITS-1:0] rd_bank;
  logic [IDX_W-1:0]         req_idx;
  logic [NB-1:0]            req_onehot;
  logic                     accept;

  logic [NB-1:0]            mem_en;
  logic                     mem_we;
  logic [NUM_SLICES-1:0]    mem_be;
  logic [IDX_W-1:0]         mem_idx;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic [NB-1:0][DATA_WIDTH-1:0] rd_word;

  // Address split: the bits not used for bank select index the word inside the bank.
  generate
    if (INTERLEAVE != 0) begin : g_ilv
      assign req_bank = req_addr[BANK_SEL_BITS-1:0];
      assign req_idx  = req_addr[ADDR_WIDTH-1:BANK_SEL_BITS];
    end else begin : g_blk
      assign req_bank = req_addr[ADDR_WIDTH-1 -: BANK_SEL_BITS];
      assign req_idx  = req_addr[IDX_W-1:0];
    end
  endgenerate

  always_comb begin
    req_onehot = '0;
    req_onehot[req_bank] = 1'b1;
  end

  // A stalled response blocks new requests so its read data cannot be overwritten.
  assign req_ready = (state == ST_RUN) && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;
  assign init_done = (state == ST_RUN);

  // Shared memory port: INIT broadcasts a zero write to every bank, RUN enables one bank.
  always_comb begin
    mem_en    = '0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_idx   = req_idx;
    mem_wdata = req_wdata;
    if (state == ST_INIT) begin
      if (CLEAR_ON_RESET != 0) begin
        mem_en = '1;
      end
      mem_we    = 1'b1;
      mem_be    = '1;
      mem_idx   = init_cnt;
      mem_wdata = '0;
    end else if (accept) begin
      mem_en = req_onehot;
      mem_we = req_we;
      mem_be = req_be;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else if (state == ST_INIT) begin
      init_cnt <= init_cnt + IDX_W'(1);
      if ((CLEAR_ON_RESET == 0) || (init_cnt == '1)) begin
        state <= ST_RUN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid   <= 1'b0;
      bank_active <= '0;
      rd_bank     <= '0;
    end else begin
      if (accept) begin
        bank_active <= req_onehot;
        if (!req_we) begin
          rd_bank <= req_bank;
        end
      end
      if (accept && !req_we) begin
        rsp_valid <= 1'b1;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  // Each bank/slice is its own array with a registered read port that only moves on a
  // read to that bank, so the response word stays put while the consumer stalls.
  for (genvar b = 0; b < NB; b++) begin : g_bank
    for (genvar s = 0; s < NUM_SLICES; s++) begin : g_slice
      logic [SLICE_W-1:0] mem [BANK_DEPTH];
      logic [SLICE_W-1:0] rd_q;

      always_ff @(posedge clk) begin
        if (mem_en[b]) begin
          if (mem_we) begin
            if (mem_be[s]) begin
              mem[mem_idx] <= mem_wdata[s*SLICE_W +: SLICE_W];
            end
          end else begin
            rd_q <= mem[mem_idx];
          end
        end
      end

      assign rd_word[b][s*SLICE_W +: SLICE_W] = rd_q;
    end
  end

  // Read registers are not reset; masking with rsp_valid gives a zero idle value.
  assign rsp_rdata = rsp_valid ? rd_word[rd_bank] : '0;

endmodule
